// File: rtl/in_debounce_if.sv
// Signal bundle between the input pads, the debouncer and the downstream process plugin.
// The master side (pads + plugin) drives raw inputs and controls; the slave side is the debouncer.
interface in_debounce_if #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CNT_W = 8
);
  logic [WIDTH-1:0] pad_in;
  logic [CNT_W-1:0] debounce_len;
  logic [WIDTH-1:0] invert;
  logic             in_enable;
  logic [WIDTH-1:0] internal_in;
  logic [WIDTH-1:0] rise_pulse;
  logic [WIDTH-1:0] fall_pulse;

  modport master (
    output pad_in,
    output debounce_len,
    output invert,
    output in_enable,
    input  internal_in,
    input  rise_pulse,
    input  fall_pulse
  );

  modport slave (
    input  pad_in,
    input  debounce_len,
    input  invert,
    input  in_enable,
    output internal_in,
    output rise_pulse,
    output fall_pulse
  );
endinterface

// File: rtl/in_debounce.sv
// Multi-channel input conditioner: 2-flop synchronizer, per-channel stability counter,
// polarity inversion and registered edge strobes keyed to the debounced (pre-invert) state.
module in_debounce #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CNT_W = 8
) (
  input logic          clk,
  input logic          rst,
  in_debounce_if.slave bus
);

  logic [WIDTH-1:0] s1_q, s2_q;
  logic [WIDTH-1:0] st_q, st_d;
  logic [WIDTH-1:0] rise_q, rise_d;
  logic [WIDTH-1:0] fall_q, fall_d;
  logic [CNT_W-1:0] cnt_q [WIDTH];
  logic [CNT_W-1:0] cnt_d [WIDTH];
  logic [CNT_W-1:0] leff_m1;

  // A length of 0 is treated as 1, so the terminal count is 0 in both cases.
  always_comb begin
    leff_m1 = '0;
    if (bus.debounce_len != '0) begin
      leff_m1 = bus.debounce_len - CNT_W'(1);
    end
  end

  // ">=" rather than "==" lets a length reduced mid-count commit on the next mismatch.
  always_comb begin
    st_d   = st_q;
    rise_d = '0;
    fall_d = '0;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = '0;
      if (bus.in_enable && (s2_q[i] != st_q[i])) begin
        if (cnt_q[i] >= leff_m1) begin
          st_d[i]   = s2_q[i];
          rise_d[i] = s2_q[i];
          fall_d[i] = ~s2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q   <= '0;
      s2_q   <= '0;
      st_q   <= '0;
      rise_q <= '0;
      fall_q <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      s1_q   <= bus.pad_in;
      s2_q   <= s1_q;
      st_q   <= st_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  // Inversion is applied after the state register so polarity changes never strobe.
  assign bus.internal_in = st_q ^ bus.invert;
  assign bus.rise_pulse  = rise_q;
  assign bus.fall_pulse  = fall_q;

endmodule

// File: tb/tb_in_debounce.sv
// Directed bench for in_debounce: one task per scenario with hand-computed expectations.
module tb_in_debounce;
  localparam int unsigned WIDTH = 16;
  localparam int unsigned CNT_W = 8;

  logic clk = 1'b0;
  logic rst;

  in_debounce_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

  in_debounce #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    step(1);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    bus.pad_in       = 16'hFFFF;
    bus.invert       = 16'h0F0F;
    bus.debounce_len = 8'd1;
    bus.in_enable    = 1'b1;
    rst = 1'b1;
    #1;
    vectors++;
    if (bus.internal_in !== 16'h0F0F) begin
      miscompares++;
      $display("FAIL reset_internal: got %h want %h", bus.internal_in, 16'h0F0F);
    end
    vectors++;
    if (bus.rise_pulse !== 16'h0000 || bus.fall_pulse !== 16'h0000) begin
      miscompares++;
      $display("FAIL reset_pulses: got rise %h fall %h want 0000", bus.rise_pulse, bus.fall_pulse);
    end
    step(3);
    vectors++;
    if (bus.internal_in !== 16'h0F0F) begin
      miscompares++;
      $display("FAIL reset_hold: got %h want %h", bus.internal_in, 16'h0F0F);
    end
    bus.pad_in = 16'h0000;
    bus.invert = 16'h0000;
    step(1);
    rst = 1'b0;
  endtask

  task automatic test_step_l4();
    bus.pad_in = 16'h0000; bus.invert = 16'h0000; bus.debounce_len = 8'd4; bus.in_enable = 1'b1;
    apply_reset();
    step(3);
    bus.pad_in = 16'h0001;
    for (int k = 1; k <= 5; k++) begin
      step(1);
      vectors++;
      if (bus.internal_in !== 16'h0000 || bus.rise_pulse !== 16'h0000) begin
        miscompares++;
        $display("FAIL l4_early edge %0d: got in %h rise %h want 0000/0000", k,
                 bus.internal_in, bus.rise_pulse);
      end
    end
    step(1);
    vectors++;
    if (bus.internal_in !== 16'h0001 || bus.rise_pulse !== 16'h0001) begin
      miscompares++;
      $display("FAIL l4_rise: got in %h rise %h want 0001/0001", bus.internal_in, bus.rise_pulse);
    end
    step(1);
    vectors++;
    if (bus.internal_in !== 16'h0001 || bus.rise_pulse !== 16'h0000) begin
      miscompares++;
      $display("FAIL l4_one_cycle: got in %h rise %h want 0001/0000", bus.internal_in,
               bus.rise_pulse);
    end
    bus.pad_in = 16'h0000;
    step(5);
    vectors++;
    if (bus.internal_in !== 16'h0001 || bus.fall_pulse !== 16'h0000) begin
      miscompares++;
      $display("FAIL l4_fall_early: got in %h fall %h want 0001/0000", bus.internal_in,
               bus.fall_pulse);
    end
    step(1);
    vectors++;
    if (bus.internal_in !== 16'h0000 || bus.fall_pulse !== 16'h0001 ||
        bus.rise_pulse !== 16'h0000) begin
      miscompares++;
      $display("FAIL l4_fall: got in %h fall %h rise %h want 0000/0001/0000", bus.internal_in,
               bus.fall_pulse, bus.rise_pulse);
    end
  endtask

  task automatic test_glitch();
    bus.pad_in = 16'h0000; bus.invert = 16'h0000; bus.debounce_len = 8'd4; bus.in_enable = 1'b1;
    apply_reset();
    step(2);
    bus.pad_in = 16'h0008;
    step(3);
    bus.pad_in = 16'h0000;
    for (int k = 1; k <= 8; k++) begin
      step(1);
      vectors++;
      if (bus.internal_in !== 16'h0000 || bus.rise_pulse !== 16'h0000 ||
          bus.fall_pulse !== 16'h0000) begin
        miscompares++;
        $display("FAIL glitch edge %0d: got in %h rise %h fall %h want all 0000", k,
                 bus.internal_in, bus.rise_pulse, bus.fall_pulse);
      end
    end
  endtask

  task automatic test_len_zero();
    for (int len = 0; len <= 1; len++) begin
      bus.pad_in = 16'h0000; bus.invert = 16'h0000; bus.in_enable = 1'b1;
      bus.debounce_len = CNT_W'(len);
      apply_reset();
      step(2);
      bus.pad_in = 16'h0002;
      step(2);
      vectors++;
      if (bus.internal_in !== 16'h0000) begin
        miscompares++;
        $display("FAIL len%0d_early: got %h want 0000", len, bus.internal_in);
      end
      step(1);
      vectors++;
      if (bus.internal_in !== 16'h0002 || bus.rise_pulse !== 16'h0002) begin
        miscompares++;
        $display("FAIL len%0d_update: got in %h rise %h want 0002/0002", len, bus.internal_in,
                 bus.rise_pulse);
      end
    end
  endtask

  task automatic test_len_change();
    bus.pad_in = 16'h0000; bus.invert = 16'h0000; bus.debounce_len = 8'd10; bus.in_enable = 1'b1;
    apply_reset();
    step(2);
    bus.pad_in = 16'h0004;
    // Two synchronizer edges plus six counting edges leave the counter at 6.
    step(8);
    vectors++;
    if (bus.internal_in !== 16'h0000) begin
      miscompares++;
      $display("FAIL lenchg_pre: got %h want 0000", bus.internal_in);
    end
    bus.debounce_len = 8'd3;
    step(1);
    vectors++;
    if (bus.internal_in !== 16'h0004 || bus.rise_pulse !== 16'h0004) begin
      miscompares++;
      $display("FAIL lenchg_commit: got in %h rise %h want 0004/0004", bus.internal_in,
               bus.rise_pulse);
    end
    step(1);
    vectors++;
    if (bus.rise_pulse !== 16'h0000 || bus.internal_in !== 16'h0004) begin
      miscompares++;
      $display("FAIL lenchg_single: got in %h rise %h want 0004/0000", bus.internal_in,
               bus.rise_pulse);
    end
  endtask

  task automatic test_invert();
    bus.pad_in = 16'h0000; bus.invert = 16'hFFFF; bus.debounce_len = 8'd2; bus.in_enable = 1'b1;
    apply_reset();
    for (int k = 1; k <= 3; k++) begin
      step(1);
      vectors++;
      if (bus.internal_in !== 16'hFFFF || bus.rise_pulse !== 16'h0000 ||
          bus.fall_pulse !== 16'h0000) begin
        miscompares++;
        $display("FAIL inv_idle edge %0d: got in %h rise %h fall %h want FFFF/0000/0000", k,
                 bus.internal_in, bus.rise_pulse, bus.fall_pulse);
      end
    end
    bus.pad_in = 16'hA5A5;
    step(3);
    vectors++;
    if (bus.internal_in !== 16'hFFFF) begin
      miscompares++;
      $display("FAIL inv_early: got %h want FFFF", bus.internal_in);
    end
    step(1);
    vectors++;
    if (bus.internal_in !== 16'h5A5A || bus.rise_pulse !== 16'hA5A5 ||
        bus.fall_pulse !== 16'h0000) begin
      miscompares++;
      $display("FAIL inv_update: got in %h rise %h fall %h want 5A5A/A5A5/0000", bus.internal_in,
               bus.rise_pulse, bus.fall_pulse);
    end
    step(1);
    vectors++;
    if (bus.rise_pulse !== 16'h0000) begin
      miscompares++;
      $display("FAIL inv_one_cycle: got rise %h want 0000", bus.rise_pulse);
    end
    bus.invert = 16'h0000;
    #1;
    vectors++;
    if (bus.internal_in !== 16'hA5A5) begin
      miscompares++;
      $display("FAIL inv_live: got %h want A5A5", bus.internal_in);
    end
    step(1);
    vectors++;
    if (bus.rise_pulse !== 16'h0000 || bus.fall_pulse !== 16'h0000) begin
      miscompares++;
      $display("FAIL inv_nopulse: got rise %h fall %h want 0000/0000", bus.rise_pulse,
               bus.fall_pulse);
    end
  endtask

  task automatic test_enable();
    bus.pad_in = 16'h0000; bus.invert = 16'h0000; bus.debounce_len = 8'd3; bus.in_enable = 1'b1;
    apply_reset();
    step(3);
    bus.in_enable = 1'b0;
    bus.pad_in    = 16'h0010;
    for (int k = 1; k <= 8; k++) begin
      step(1);
      vectors++;
      if (bus.internal_in !== 16'h0000 || bus.rise_pulse !== 16'h0000) begin
        miscompares++;
        $display("FAIL en_frozen edge %0d: got in %h rise %h want 0000/0000", k,
                 bus.internal_in, bus.rise_pulse);
      end
    end
    bus.in_enable = 1'b1;
    step(2);
    vectors++;
    if (bus.internal_in !== 16'h0000) begin
      miscompares++;
      $display("FAIL en_restart: got %h want 0000", bus.internal_in);
    end
    step(1);
    vectors++;
    if (bus.internal_in !== 16'h0010 || bus.rise_pulse !== 16'h0010) begin
      miscompares++;
      $display("FAIL en_update: got in %h rise %h want 0010/0010", bus.internal_in,
               bus.rise_pulse);
    end
  endtask

  task automatic test_rst_midcount();
    bus.pad_in = 16'h0000; bus.invert = 16'h0000; bus.debounce_len = 8'd8; bus.in_enable = 1'b1;
    apply_reset();
    bus.pad_in = 16'h0040;
    step(10);
    vectors++;
    if (bus.internal_in !== 16'h0040) begin
      miscompares++;
      $display("FAIL rstmid_setup: got %h want 0040", bus.internal_in);
    end
    bus.pad_in = 16'h0060;
    step(5);
    rst = 1'b1;
    #1;
    vectors++;
    if (bus.internal_in !== 16'h0000 || bus.rise_pulse !== 16'h0000 ||
        bus.fall_pulse !== 16'h0000) begin
      miscompares++;
      $display("FAIL rstmid_async: got in %h rise %h fall %h want all 0000", bus.internal_in,
               bus.rise_pulse, bus.fall_pulse);
    end
    step(1);
    rst = 1'b0;
    step(9);
    vectors++;
    if (bus.internal_in !== 16'h0000 || bus.rise_pulse !== 16'h0000) begin
      miscompares++;
      $display("FAIL rstmid_early: got in %h rise %h want 0000/0000", bus.internal_in,
               bus.rise_pulse);
    end
    step(1);
    vectors++;
    if (bus.internal_in !== 16'h0060 || bus.rise_pulse !== 16'h0060) begin
      miscompares++;
      $display("FAIL rstmid_release_rise: got in %h rise %h want 0060/0060", bus.internal_in,
               bus.rise_pulse);
    end
  endtask

  task automatic test_back_to_back();
    bus.pad_in = 16'h0000; bus.invert = 16'h0000; bus.debounce_len = 8'd1; bus.in_enable = 1'b1;
    apply_reset();
    bus.pad_in = 16'h00FF;
    step(2);
    vectors++;
    if (bus.internal_in !== 16'h0000) begin
      miscompares++;
      $display("FAIL b2b_early: got %h want 0000", bus.internal_in);
    end
    step(1);
    vectors++;
    if (bus.internal_in !== 16'h00FF || bus.rise_pulse !== 16'h00FF) begin
      miscompares++;
      $display("FAIL b2b_first: got in %h rise %h want 00FF/00FF", bus.internal_in,
               bus.rise_pulse);
    end
    bus.pad_in = 16'hFF00;
    step(3);
    vectors++;
    if (bus.internal_in !== 16'hFF00 || bus.rise_pulse !== 16'hFF00 ||
        bus.fall_pulse !== 16'h00FF) begin
      miscompares++;
      $display("FAIL b2b_swap: got in %h rise %h fall %h want FF00/FF00/00FF", bus.internal_in,
               bus.rise_pulse, bus.fall_pulse);
    end
    vectors++;
    if ((bus.rise_pulse & bus.fall_pulse) !== 16'h0000) begin
      miscompares++;
      $display("FAIL b2b_exclusive: got overlap %h want 0000", bus.rise_pulse & bus.fall_pulse);
    end
    bus.pad_in = 16'h0000;
    step(3);
    vectors++;
    if (bus.internal_in !== 16'h0000 || bus.fall_pulse !== 16'hFF00 ||
        bus.rise_pulse !== 16'h0000) begin
      miscompares++;
      $display("FAIL b2b_release: got in %h rise %h fall %h want 0000/0000/FF00", bus.internal_in,
               bus.rise_pulse, bus.fall_pulse);
    end
  endtask

  initial begin
    test_reset();
    test_step_l4();
    test_glitch();
    test_len_zero();
    test_len_change();
    test_invert();
    test_enable();
    test_rst_midcount();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/in_debounce.md
IN_DEBOUNCE -- requirements
Module: in_debounce

Interface
REQ-001 Parameter WIDTH, default 16, number of independent input channels.
REQ-002 Parameter CNT_W, default 8, width of the debounce length and per-channel counters.
REQ-003 clk  input  1  single system clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 pad_in  input  WIDTH  raw physical inputs, asynchronous to clk.
REQ-006 debounce_len  input  CNT_W  required stable cycles L, shared by all channels, sampled live every cycle.
REQ-007 invert  input  WIDTH  per-channel polarity; 1 inverts the debounced value on internal_in.
REQ-008 in_enable  input  1  driven by the downstream process plugin's input_enable; 0 freezes conditioning.
REQ-009 internal_in  output  WIDTH  conditioned inputs, consumed directly by the process plugin.
REQ-010 rise_pulse  output  WIDTH  one-cycle strobe per channel on a debounced 0->1 transition.
REQ-011 fall_pulse  output  WIDTH  one-cycle strobe per channel on a debounced 1->0 transition.

Function
REQ-012 Each pad_in bit SHALL pass a 2-flop synchronizer (s1, s2) before any other logic.
REQ-013 Per channel, state is stable bit st[i] plus counter cnt[i] (CNT_W bits).
REQ-014 Leff SHALL be max(debounce_len, 1); L=0 behaves exactly as L=1.
REQ-015 Mismatch cycle: in_enable=1 and s2[i] != st[i].
REQ-016 On a mismatch cycle with cnt[i] < Leff-1: cnt[i] <= cnt[i]+1, st[i] unchanged.
REQ-017 On a mismatch cycle with cnt[i] >= Leff-1: st[i] <= s2[i], cnt[i] <= 0 (>= covers debounce_len reduced mid-count).
REQ-018 Any non-mismatch cycle SHALL clear cnt[i] to 0 (glitch shorter than Leff is discarded).
REQ-019 cnt[i] SHALL never wrap; Leff <= 2^CNT_W-1 guarantees saturation is unreachable.
REQ-020 internal_in[i] SHALL equal st[i] XOR invert[i], combinational in invert (invert change visible same cycle, no pulse).
REQ-021 rise_pulse[i]/fall_pulse[i] SHALL be registered, high for exactly the one cycle in which st[i] shows its new value, keyed to st (pre-invert).
REQ-022 Latency pad_in change (sampled at edge 0) -> st update SHALL be 2+Leff rising edges, given pad held stable.
REQ-023 in_enable=0: st and internal_in hold, all cnt cleared, no pulses; synchronizer keeps running.
REQ-024 in_enable 0->1: counting restarts from 0; a pending difference needs a full Leff cycles.
REQ-025 Channels SHALL be fully independent; simultaneous transitions on several channels all pulse in the same cycle.
REQ-026 rise_pulse and fall_pulse for one channel SHALL never be high in the same cycle.

Reset
REQ-027 rst=1 SHALL immediately clear s1, s2, st, cnt, rise_pulse, fall_pulse; internal_in = invert.
REQ-028 After rst release, a pad held high SHALL be reported as a normal rising edge after 2+Leff edges.
REQ-029 rst mid-count SHALL discard the count; no pulse is produced for the interrupted transition.

Verification
REQ-030 L=4, in_enable=1, pad_in[0] 0->1 held -> internal_in[0]=1 and rise_pulse[0]=1 for one cycle exactly 6 edges later.
REQ-031 L=4, pad_in[3] high for 3 cycles then low -> internal_in[3] stays 0, no pulses.
REQ-032 L=0 vs L=1, same 0->1 step -> both give internal_in change 3 edges later.
REQ-033 L=10, count reaches 6, debounce_len changed to 3 -> st updates on the next mismatch edge, single pulse.
REQ-034 invert=0xFFFF after reset, all pads 0 -> internal_in=0xFFFF, no pulses; pads 0xA5A5 held with L=2 -> internal_in=0x5A5A after 4 edges, rise_pulse=0xA5A5 for one cycle.
REQ-035 in_enable=0 during a pad change, then 1 -> no change while disabled; update Leff edges after re-enable; rst asserted mid-count -> all outputs cleared asynchronously.
